// File: rtl/data_ram_arbiter.sv
// Two-master round-robin arbiter that serialises accesses to the single-port data RAM.
// Each access takes an ACCESS cycle on the RAM, followed by a RESP cycle carrying the ack.
module data_ram_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_sel,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_sel,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,

    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic              gnt_q;
    logic              last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        sel_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;

    logic              elig0;
    logic              elig1;
    logic              win;
    logic              latch_en;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [3:0]        win_sel;
    logic [DATA_W-1:0] win_wdata;
    logic [DATA_W-1:0] access_rdata;
    logic              in_access;
    logic              in_resp;

    // The master just served still holds req during RESP; it must not win again.
    always_comb begin
        elig0 = m0_req && !(state_q == StResp && gnt_q == 1'b0);
        elig1 = m1_req && !(state_q == StResp && gnt_q == 1'b1);
    end

    always_comb begin
        win = 1'b0;
        if (elig0 && elig1) begin
            win = ~last_q;
        end else if (elig1) begin
            win = 1'b1;
        end
    end

    always_comb begin
        win_we    = m0_we;
        win_addr  = m0_addr;
        win_sel   = m0_sel;
        win_wdata = m0_wdata;
        if (win) begin
            win_we    = m1_we;
            win_addr  = m1_addr;
            win_sel   = m1_sel;
            win_wdata = m1_wdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        unique case (state_q)
            StIdle, StResp: begin
                if (elig0 || elig1) begin
                    latch_en = 1'b1;
                    state_d  = StAccess;
                end else begin
                    state_d  = StIdle;
                end
            end
            StAccess: begin
                state_d = StResp;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Writes and empty-lane accesses return zero to the requester.
    always_comb begin
        access_rdata = '0;
        if (!we_q && (sel_q != 4'b0000)) begin
            access_rdata = ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            sel_q      <= 4'b0000;
            wdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                gnt_q   <= win;
                last_q  <= win;
                we_q    <= win_we;
                addr_q  <= win_addr;
                sel_q   <= win_sel;
                wdata_q <= win_wdata;
            end
            if (state_q == StAccess) begin
                if (gnt_q) begin
                    m1_rdata_q <= access_rdata;
                end else begin
                    m0_rdata_q <= access_rdata;
                end
            end
        end
    end

    // Reset gates every strobe so nothing is committed or acknowledged while rst is high.
    always_comb begin
        in_access = (state_q == StAccess) && !rst;
        in_resp   = (state_q == StResp) && !rst;
    end

    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_sel   = 4'b0000;
        ram_wdata = '0;
        if (in_access) begin
            ram_ce    = (sel_q != 4'b0000);
            ram_we    = (sel_q != 4'b0000) && we_q;
            ram_addr  = addr_q;
            ram_sel   = sel_q;
            ram_wdata = wdata_q;
        end
    end

    always_comb begin
        m0_ack   = in_resp && (gnt_q == 1'b0);
        m1_ack   = in_resp && (gnt_q == 1'b1);
        m0_rdata = m0_rdata_q;
        m1_rdata = m1_rdata_q;
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model with its own golden memory.
module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_req   [2];
    logic        d_we    [2];
    logic [31:0] d_addr  [2];
    logic [3:0]  d_sel   [2];
    logic [31:0] d_wdata [2];

    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;

    always #5 clk = ~clk;

    data_ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(d_req[0]), .m0_we(d_we[0]), .m0_addr(d_addr[0]), .m0_sel(d_sel[0]),
        .m0_wdata(d_wdata[0]), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(d_req[1]), .m1_we(d_we[1]), .m1_addr(d_addr[1]), .m1_sel(d_sel[1]),
        .m1_wdata(d_wdata[1]), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // RAM seen by the DUT: 16 words, combinational read, byte-lane write.
    logic [31:0] ram_mem [16];
    assign ram_rdata = ram_mem[ram_addr[5:2]];
    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_sel[b]) ram_mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Transaction-level model: phase 0 = nobody served, 1 = access on RAM, 2 = ack.
    int          md_phase = 0;
    int          md_cur = 0;
    int          md_lg = 1;
    logic        md_we = 1'b0;
    logic [31:0] md_addr = '0;
    logic [3:0]  md_sel = '0;
    logic [31:0] md_wdata = '0;
    logic [31:0] md_rd [2];
    logic [31:0] gold [16];

    int n_cmp = 0;
    int n_bad = 0;
    int ce_cycles = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic acc, e_ce;
        acc  = !rst && md_phase == 1;
        e_ce = acc && md_sel != 4'b0000;
        cmp("ram_ce", 32'(ram_ce), 32'(e_ce));
        cmp("ram_we", 32'(ram_we), 32'(e_ce && md_we));
        cmp("ram_addr", ram_addr, acc ? md_addr : 32'h0);
        cmp("ram_sel", 32'(ram_sel), acc ? 32'(md_sel) : 32'h0);
        cmp("ram_wdata", ram_wdata, acc ? md_wdata : 32'h0);
        cmp("m0_ack", 32'(m0_ack), 32'(!rst && md_phase == 2 && md_cur == 0));
        cmp("m1_ack", 32'(m1_ack), 32'(!rst && md_phase == 2 && md_cur == 1));
        cmp("m0_rdata", m0_rdata, md_rd[0]);
        cmp("m1_rdata", m1_rdata, md_rd[1]);
    endtask

    task automatic model_step();
        bit e0, e1;
        int w;
        if (rst) begin
            md_phase = 0; md_lg = 1; md_cur = 0;
            md_we = 1'b0; md_addr = '0; md_sel = '0; md_wdata = '0;
            md_rd[0] = '0; md_rd[1] = '0;
        end else if (md_phase == 1) begin
            if (md_we || md_sel == 4'b0000) begin
                md_rd[md_cur] = '0;
            end else begin
                md_rd[md_cur] = gold[md_addr[5:2]];
            end
            if (md_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (md_sel[b]) gold[md_addr[5:2]][8*b +: 8] = md_wdata[8*b +: 8];
                end
            end
            md_phase = 2;
        end else begin
            e0 = d_req[0] && !(md_phase == 2 && md_cur == 0);
            e1 = d_req[1] && !(md_phase == 2 && md_cur == 1);
            if (e0 || e1) begin
                w = (e0 && e1) ? 1 - md_lg : (e1 ? 1 : 0);
                md_cur = w; md_lg = w;
                md_we = d_we[w]; md_addr = d_addr[w]; md_sel = d_sel[w]; md_wdata = d_wdata[w];
                md_phase = 1;
            end else begin
                md_phase = 0;
            end
        end
    endtask

    // One clock cycle: inputs are already applied; check, update model, move to next negedge.
    task automatic advance();
        #1;
        if (chk_en) check_outputs();
        if (ram_ce === 1'b1) ce_cycles++;
        model_step();
        @(negedge clk);
    endtask

    task automatic do_req(input int m, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata);
        int i;
        d_req[m] = 1'b1; d_we[m] = we; d_addr[m] = addr; d_sel[m] = sel; d_wdata[m] = wdata;
        for (i = 0; i < 10 && !(md_phase == 2 && md_cur == m); i++) advance();
        cmp("req_done_in_bound", 32'(i < 10), 32'h1);
        cmp("req_ack", 32'(m == 0 ? m0_ack : m1_ack), 32'h1);
        d_req[m] = 1'b0;
        advance();
    endtask

    task automatic rand_fields(input int m);
        d_we[m]    = 1'($urandom);
        d_addr[m]  = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
        d_sel[m]   = 4'($urandom);
        d_wdata[m] = $urandom;
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 16; i++) begin ram_mem[i] = '0; gold[i] = '0; end
        md_rd[0] = '0; md_rd[1] = '0;
        for (int m = 0; m < 2; m++) begin
            d_req[m] = 1'b0; d_we[m] = 1'b0; d_addr[m] = '0; d_sel[m] = '0; d_wdata[m] = '0;
        end
        @(negedge clk);
        advance();
        chk_en = 1'b1;
        advance();
        cmp("reset_m0_rdata", m0_rdata, 32'h0);
        cmp("reset_m1_ack", 32'(m1_ack), 32'h0);
        rst = 1'b0;

        // Single write: strobe in N+1, ack in N+2 with zero read data.
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h10; d_sel[0] = 4'hF;
        d_wdata[0] = 32'hDEADBEEF;
        ce_cycles = 0;
        advance();
        cmp("wr_ce", 32'(ram_ce && ram_we), 32'h1);
        cmp("wr_addr", ram_addr, 32'h10);
        advance();
        cmp("wr_ack", 32'(m0_ack), 32'h1);
        cmp("wr_rdata", m0_rdata, 32'h0);
        d_req[0] = 1'b0;
        advance();
        cmp("wr_ce_cycles", 32'(ce_cycles), 32'h1);

        do_req(0, 1'b0, 32'h10, 4'hF, 32'h0);
        cmp("rd_deadbeef", m0_rdata, 32'hDEADBEEF);

        do_req(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
        do_req(0, 1'b1, 32'h20, 4'h8, 32'hAA000000);
        do_req(0, 1'b0, 32'h20, 4'hF, 32'h0);
        cmp("byte_lane_merge", m0_rdata, 32'hAA223344);

        ce_cycles = 0;
        do_req(0, 1'b0, 32'h20, 4'h0, 32'h0);
        cmp("sel0_rdata", m0_rdata, 32'h0);
        cmp("sel0_no_ce", 32'(ce_cycles), 32'h0);

        // Simultaneous requests straight out of reset: m0 wins the first tie.
        rst = 1'b1; advance(); advance(); rst = 1'b0;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h10; d_sel[0] = 4'hF;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h20; d_sel[1] = 4'hF;
        advance();
        cmp("tie_first_addr", ram_addr, 32'h10);
        advance();
        cmp("tie_m0_ack", 32'(m0_ack), 32'h1);
        d_req[0] = 1'b0;
        advance();
        cmp("tie_second_ce", 32'(ram_ce), 32'h1);
        cmp("tie_second_addr", ram_addr, 32'h20);
        advance();
        cmp("tie_m1_ack", 32'(m1_ack), 32'h1);
        cmp("tie_m1_rdata", m1_rdata, 32'hAA223344);
        d_req[1] = 1'b0;
        advance();

        // After a solo m0 access, a tie goes to m1.
        do_req(0, 1'b0, 32'h10, 4'hF, 32'h0);
        d_req[0] = 1'b1; d_req[1] = 1'b1;
        advance(); advance();
        cmp("tie2_m1_first", 32'(m1_ack), 32'h1);
        cmp("tie2_m0_waits", 32'(m0_ack), 32'h0);
        d_req[1] = 1'b0;
        advance(); advance();
        cmp("tie2_m0_ack", 32'(m0_ack), 32'h1);
        d_req[0] = 1'b0;
        advance();

        // m1 streaming; m0 joins during an m1 access and is latched in m1's RESP.
        d_req[1] = 1'b1;
        advance();
        d_req[0] = 1'b1; d_addr[0] = 32'h10;
        waited = 0;
        while (waited < 6 && !(ram_ce === 1'b1 && ram_addr == 32'h10 && md_cur == 0)) begin
            advance();
            waited++;
        end
        cmp("m0_wait_cycles", 32'(waited), 32'h2);
        advance();
        d_req[0] = 1'b0; d_req[1] = 1'b0;
        for (int i = 0; i < 4; i++) advance();

        // Fields change and req drops during ACCESS: latched values still used, ack still pulses.
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h30; d_sel[0] = 4'hF;
        advance();
        d_addr[0] = 32'h40; d_req[0] = 1'b0;
        #1;
        cmp("stable_addr", ram_addr, 32'h30);
        advance();
        cmp("dropped_req_ack", 32'(m0_ack), 32'h1);
        advance();

        // Reset during the ACCESS cycle of a write discards it.
        do_req(0, 1'b1, 32'h50, 4'hF, 32'hCAFEF00D);
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h50; d_wdata[0] = 32'h12345678;
        advance();
        rst = 1'b1; d_req[0] = 1'b0;
        #1;
        cmp("midop_rst_ce", 32'(ram_ce), 32'h0);
        advance();
        rst = 1'b0;
        cmp("midop_rst_no_ack", 32'(m0_ack), 32'h0);
        advance();
        cmp("midop_rst_no_ack2", 32'(m0_ack), 32'h0);
        do_req(0, 1'b0, 32'h50, 4'hF, 32'h0);
        cmp("midop_prior_data", m0_rdata, 32'hCAFEF00D);

        // Random traffic, including protocol violations and occasional resets.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int m = 0; m < 2; m++) begin
                if (rst) begin
                    d_req[m] = 1'b0;
                end else if (md_phase == 2 && md_cur == m) begin
                    d_req[m] = ($urandom_range(0, 2) == 0);
                    if (d_req[m]) rand_fields(m);
                end else if (md_phase == 1 && md_cur == m) begin
                    if ($urandom_range(0, 1) == 0) rand_fields(m);
                    if ($urandom_range(0, 9) == 0) d_req[m] = 1'b0;
                end else if (!d_req[m]) begin
                    if ($urandom_range(0, 9) < (m == 0 ? 3 : 6)) begin
                        d_req[m] = 1'b1;
                        rand_fields(m);
                    end
                end
            end
            advance();
        end
        rst = 1'b0; d_req[0] = 1'b0; d_req[1] = 1'b0;
        for (int i = 0; i < 4; i++) advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
Two-master round-robin arbiter and access sequencer in front of the single-port data RAM. Master 0 is the MEM-stage load/store path; master 1 is a secondary port (debug/loader/DMA). Each access is serialized: latch the request, drive one RAM access cycle, then return an ack pulse with registered read data. All RAM control signals are owned by this block.

Parameters:
ADDR_W, 32, address width of masters and RAM (matches RegBus)
DATA_W, 32, data width (matches RegBus)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m0_req  in  1  master 0 request; held high until m0_ack
m0_we  in  1  1 = write, 0 = read
m0_addr  in  ADDR_W  byte address (word index taken by RAM from addr[18:2])
m0_sel  in  4  byte lane enables; bit3 = data[31:24]
m0_wdata  in  DATA_W  write data
m0_rdata  out  DATA_W  read data; valid in m0_ack cycle, held until next m0_ack
m0_ack  out  1  one-cycle completion pulse
m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_rdata, m1_ack  as master 0, for master 1
ram_ce  out  1  RAM chip enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_sel  out  4  RAM byte selects
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data (combinational from RAM in same cycle)

Behaviour:
- Reset: state=IDLE; m0_ack=m1_ack=0; m0_rdata=m1_rdata=0; last_grant=1 (master 0 wins the first tie); latched request fields cleared.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, pick a winner, latch its we/addr/sel/wdata and grant id, then go to ACCESS. Otherwise stay in IDLE.
- Winner selection: if only one req is high, that master wins. If both are high, the master != last_grant wins. last_grant updates on the latch.
- ACCESS (one cycle): ram_ce=1, ram_we=latched we, ram_addr/ram_sel/ram_wdata driven from the latched fields.
  - Write commits at the closing clk edge.
  - Read: ram_rdata is captured at the closing edge into the granted master's rdata register.
  - Write: the granted master's rdata register is loaded with 0.
  - Next state is RESP.
- RESP (one cycle): the granted master's ack=1.
  - Arbitration runs in the same cycle as IDLE, except the served master's req is ignored in this cycle (its req is still high by protocol).
  - If the other master is requesting, latch it and go to ACCESS. Otherwise go to IDLE.
- Latency: req seen in IDLE at cycle N -> RAM access in N+1 -> ack in N+2.
- Sustained throughput: one access per 2 cycles when masters alternate. A single master re-requesting gets one access per 3 cycles (RESP -> IDLE -> ACCESS).
- RAM outputs outside ACCESS: ram_ce=0, ram_we=0, ram_addr=0, ram_sel=0, ram_wdata=0.
- All ram_* outputs are forced to 0 in any cycle where rst=1, so no write is committed during reset.
- Request fields are sampled only at grant. Changes to addr/we/sel/wdata after grant are ignored until ack.
- sel==0 request: ram_ce stays 0 in its ACCESS cycle, ack is still issued, rdata=0.
- req dropped before ack (protocol violation): the access still completes and ack still pulses. No error is flagged.
- Reset mid-operation (ACCESS or RESP): the in-flight access is discarded, no ack is issued, and the block returns to the reset values on the next cycle.
- The non-granted master's ack and rdata are unchanged while the other master is served.
- No combinational path from any m*_req to ram_* or to ack. All outputs are decoded from state and registers, plus the rst gate.

Test Plan:
- Single write then read, master 0:
  - Write addr=0x10, sel=4'b1111, wdata=0xDEADBEEF -> ram_ce/ram_we high exactly one cycle, m0_ack at N+2, m0_rdata=0.
  - Read addr=0x10 -> m0_rdata=0xDEADBEEF at ack.
- Byte lanes:
  - Write 0x11223344 sel=1111 to 0x20, then 0xAA000000 sel=1000, then read -> 0xAA223344.
  - A sel=0000 request -> no ram_ce, ack issued, rdata=0.
- Simultaneous requests from reset: m0 and m1 both request reads -> m0 granted first (ack cycle 2), m1 latched in m0's RESP cycle with ram_ce in cycle 3 and ack in cycle 4. Repeat with both requesting -> m1 is served first.
- Continuous m1 requests while m0 requests once: m1 and m0 alternate grants. m0 waits at most one in-progress access plus one m1 access before its ACCESS cycle.
- Field stability: change m0_addr from 0x30 to 0x40 in the ACCESS cycle -> ram_addr stays 0x30. Drop m0_req in ACCESS -> ack still pulses.
- Reset mid-op: assert rst during the ACCESS cycle of a write to 0x50 with 0x12345678 -> ram_ce=0 in that cycle, no ack. A later read of 0x50 returns the prior contents.
